// File: rtl/lane_capture_pipe_if.sv
// Handshake bundle for lane_capture_pipe: lane-striped input beats and a
// backpressured output stream.
interface lane_capture_pipe_if #(
   parameter int unsigned LANES = 4,
   parameter int unsigned WIDTH = 1,
   parameter int unsigned DEPTH = 2
);
   logic                           in_valid;
   logic                           in_ready;
   logic [LANES*WIDTH-1:0]         in_data;
   logic [LANES-1:0]               lane_en;
   logic                           accumulate;
   logic                           out_valid;
   logic                           out_ready;
   logic [LANES*WIDTH-1:0]         out_data;
   logic [$clog2(DEPTH+1)-1:0]     occupancy;

   modport master (
      output in_valid, in_data, lane_en, accumulate, out_ready,
      input  in_ready, out_valid, out_data, occupancy
   );

   modport slave (
      input  in_valid, in_data, lane_en, accumulate, out_ready,
      output in_ready, out_valid, out_data, occupancy
   );
endinterface

// File: rtl/lane_capture_pipe.sv
// Per-lane capture shadows (replace / hold / OR-accumulate) feeding a DEPTH-stage
// stallable valid/ready pipeline with a combinational ready chain.
module lane_capture_pipe #(
   parameter int unsigned LANES = 4,
   parameter int unsigned WIDTH = 1,
   parameter int unsigned DEPTH = 2
) (
   input logic                clk,
   input logic                rst,
   lane_capture_pipe_if.slave bus
);
   localparam int unsigned DW = LANES * WIDTH;
   localparam int unsigned OW = $clog2(DEPTH + 1);

   logic [DW-1:0]    shadow_q;
   logic [DW-1:0]    new_data;
   logic             accept;
   logic             in_ready;
   logic [DEPTH-1:0] adv;
   logic [DEPTH-1:0] stage_valid;
   logic [DW-1:0]    stage_data [DEPTH];
   logic [OW-1:0]    occ;

   // A stage may advance when every stage downstream of it is either empty or moving.
   always_comb begin : p_adv
      logic take;
      take = bus.out_ready;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         adv[k] = take;
         take   = !stage_valid[k] || take;
      end
      in_ready = take;
   end

   assign accept = bus.in_valid && in_ready;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic [WIDTH-1:0] lane_in;
      logic [WIDTH-1:0] lane_sh;
      assign lane_in = bus.in_data[i*WIDTH +: WIDTH];
      assign lane_sh = shadow_q[i*WIDTH +: WIDTH];
      assign new_data[i*WIDTH +: WIDTH] = !bus.lane_en[i] ? lane_sh :
                                          bus.accumulate  ? (lane_sh | lane_in) : lane_in;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_q <= '0;
      end else if (accept) begin
         shadow_q <= new_data;
      end
   end

   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      logic          valid_q;
      logic [DW-1:0] data_q;
      logic          load;
      logic [DW-1:0] src;

      if (k == 0) begin : g_head
         assign load = accept;
         assign src  = new_data;
      end else begin : g_body
         assign load = stage_valid[k-1] && adv[k-1];
         assign src  = stage_data[k-1];
      end

      // Data only moves on a transfer; it is left stale while the stage is empty.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
         end else begin
            valid_q <= load || (valid_q && !adv[k]);
            if (load) begin
               data_q <= src;
            end
         end
      end

      assign stage_valid[k] = valid_q;
      assign stage_data[k]  = data_q;
   end

   always_comb begin
      occ = '0;
      for (int k = 0; k < DEPTH; k++) begin
         occ = occ + OW'(stage_valid[k]);
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = stage_valid[DEPTH-1];
   assign bus.out_data  = stage_data[DEPTH-1];
   assign bus.occupancy = occ;
endmodule

// File: tb/tb_lane_capture_pipe.sv
// Directed bench for lane_capture_pipe: a FIFO-with-minimum-latency model is
// checked every cycle, plus hand-computed literal checks on key cycles.
module tb_lane_capture_pipe;
   localparam int unsigned LANES = 4;
   localparam int unsigned WIDTH = 1;
   localparam int unsigned DEPTH = 2;
   localparam int unsigned DW    = LANES * WIDTH;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   lane_capture_pipe_if #(.LANES(LANES), .WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   lane_capture_pipe #(.LANES(LANES), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Model: beats form a FIFO; a beat accepted at end of cycle c may be shown
   // from cycle c+DEPTH, and never before the cycle after its predecessor left.
   typedef struct {
      logic [DW-1:0] d;
      int            base;
   } beat_t;

   beat_t         mq[$];
   logic [DW-1:0] m_sh = '0;
   int            cyc = 0;
   int            last_pop = -1;

   always begin
      @(negedge clk or posedge rst);
      if (rst) begin
         mq.delete();
         m_sh     = '0;
         last_pop = -1;
      end else begin
         logic          exp_ir;
         logic          exp_ov;
         logic [DW-1:0] nv;
         int            avail;
         cyc++;
         exp_ir = bus.out_ready || (mq.size() < DEPTH);
         exp_ov = 1'b0;
         if (mq.size() > 0) begin
            avail  = (mq[0].base > last_pop + 1) ? mq[0].base : last_pop + 1;
            exp_ov = (cyc >= avail);
         end
         check("cmp_in_ready", 32'(bus.in_ready), 32'(exp_ir));
         check("cmp_out_valid", 32'(bus.out_valid), 32'(exp_ov));
         check("cmp_occupancy", 32'(bus.occupancy), 32'(mq.size()));
         if (exp_ov) check("cmp_out_data", 32'(bus.out_data), 32'(mq[0].d));
         if (exp_ov && bus.out_ready) begin
            void'(mq.pop_front());
            last_pop = cyc;
         end
         if (bus.in_valid && exp_ir) begin
            nv = m_sh;
            for (int i = 0; i < LANES; i++) begin
               if (bus.lane_en[i]) begin
                  nv[i*WIDTH +: WIDTH] = bus.accumulate ?
                     (m_sh[i*WIDTH +: WIDTH] | bus.in_data[i*WIDTH +: WIDTH]) :
                     bus.in_data[i*WIDTH +: WIDTH];
               end
            end
            m_sh = nv;
            mq.push_back('{d: nv, base: cyc + DEPTH});
         end
      end
   end

   task automatic drive(input logic v, input logic [DW-1:0] d, input logic [LANES-1:0] en,
                        input logic acc, input logic ordy);
      bus.in_valid   = v;
      bus.in_data    = d;
      bus.lane_en    = en;
      bus.accumulate = acc;
      bus.out_ready  = ordy;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Pass-through: 1010 accepted in cycle 0
      tick(); drive(1'b1, 4'b1010, 4'b1111, 1'b0, 1'b1);
      #1 check("pt_c0_in_ready", 32'(bus.in_ready), 1);
      tick(); drive(1'b0, 4'b0000, 4'b1111, 1'b0, 1'b1);
      #1 check("pt_c1_valid", 32'(bus.out_valid), 0);
      check("pt_c1_occ", 32'(bus.occupancy), 1);
      tick(); #1;
      check("pt_c2_valid", 32'(bus.out_valid), 1);
      check("pt_c2_data", 32'(bus.out_data), 32'b1010);
      check("pt_c2_occ", 32'(bus.occupancy), 1);
      tick(); #1;
      check("pt_c3_valid", 32'(bus.out_valid), 0);
      check("pt_c3_occ", 32'(bus.occupancy), 0);

      // Lane hold
      tick(); drive(1'b1, 4'b0101, 4'b0011, 1'b0, 1'b1);
      tick(); drive(1'b1, 4'b1111, 4'b0000, 1'b0, 1'b1);
      tick(); drive(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1);
      #1 check("hold_a_data", 32'(bus.out_data), 32'b1001);
      check("hold_a_valid", 32'(bus.out_valid), 1);
      tick(); #1;
      check("hold_b_data", 32'(bus.out_data), 32'b1001);
      check("hold_b_valid", 32'(bus.out_valid), 1);
      tick();

      // Asynchronous reset pulse between edges
      #1 rst = 1'b1;
      #1;
      check("rst_out_valid", 32'(bus.out_valid), 0);
      check("rst_out_data", 32'(bus.out_data), 0);
      check("rst_occ", 32'(bus.occupancy), 0);
      check("rst_in_ready", 32'(bus.in_ready), 1);
      tick(); #1 rst = 1'b0;

      // Accumulate from cleared shadows
      tick(); drive(1'b1, 4'b0001, 4'b1111, 1'b1, 1'b1);
      tick(); drive(1'b1, 4'b0100, 4'b1111, 1'b1, 1'b1);
      tick(); drive(1'b1, 4'b0000, 4'b1111, 1'b1, 1'b1);
      #1 check("acc_c2_data", 32'(bus.out_data), 32'b0001);
      tick(); drive(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1);
      #1 check("acc_c3_data", 32'(bus.out_data), 32'b0101);
      tick(); #1;
      check("acc_c4_data", 32'(bus.out_data), 32'b0101);
      check("acc_c4_valid", 32'(bus.out_valid), 1);
      tick(); tick();

      // Backpressure
      tick(); drive(1'b1, 4'b0001, 4'b1111, 1'b0, 1'b0);
      #1 check("bp_c0_in_ready", 32'(bus.in_ready), 1);
      tick(); drive(1'b1, 4'b0010, 4'b1111, 1'b0, 1'b0);
      #1 check("bp_c1_in_ready", 32'(bus.in_ready), 1);
      tick(); drive(1'b1, 4'b0011, 4'b1111, 1'b0, 1'b0);
      #1 check("bp_full_in_ready", 32'(bus.in_ready), 0);
      check("bp_full_occ", 32'(bus.occupancy), 2);
      check("bp_full_data", 32'(bus.out_data), 32'b0001);
      tick(); drive(1'b1, 4'b0011, 4'b1111, 1'b0, 1'b1);
      #1 check("bp_pop_in_ready", 32'(bus.in_ready), 1);
      check("bp_pop_data", 32'(bus.out_data), 32'b0001);
      tick(); drive(1'b0, 4'b0000, 4'b1111, 1'b0, 1'b1);
      #1 check("bp_c4_occ", 32'(bus.occupancy), 2);
      check("bp_c4_data", 32'(bus.out_data), 32'b0010);
      tick(); #1;
      check("bp_c5_occ", 32'(bus.occupancy), 1);
      check("bp_c5_data", 32'(bus.out_data), 32'b0011);
      tick(); #1;
      check("bp_c6_occ", 32'(bus.occupancy), 0);

      // Reset with two beats in flight
      tick(); drive(1'b1, 4'b1111, 4'b1111, 1'b0, 1'b0);
      tick(); drive(1'b1, 4'b0110, 4'b1111, 1'b0, 1'b0);
      tick(); drive(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
      #1 check("rmid_pre_occ", 32'(bus.occupancy), 2);
      #1 rst = 1'b1;
      #1;
      check("rmid_occ", 32'(bus.occupancy), 0);
      check("rmid_valid", 32'(bus.out_valid), 0);
      check("rmid_data", 32'(bus.out_data), 0);
      tick(); #1 rst = 1'b0;
      tick(); drive(1'b1, 4'b1010, 4'b0000, 1'b0, 1'b1);
      tick(); drive(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1);
      tick(); #1;
      check("rmid_post_valid", 32'(bus.out_valid), 1);
      check("rmid_post_data", 32'(bus.out_data), 32'b0000);
      repeat (3) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
